// File: rtl/fip_32_cramer_ctrl.sv
// ---------------------------------------------------------------------------
// fip_32_cramer_ctrl
//
// Solves a 3x3 linear system A*x = b in Q16.16 by Cramer's rule. One
// pipelined determinant unit and one combinational divider are shared over
// time: four determinants (A, then A with each column replaced by b) are
// issued back to back, collected as they leave the pipeline, and then the
// three numerators are divided by det(A) one per cycle.
//
// Ports (fip_32_cramer_ctrl):
//   i_clk       clock
//   i_rst       synchronous, active-high reset
//   i_valid     upstream request valid
//   o_ready     controller idle and able to accept a request
//   i_matrix    A[row][col], signed Q16.16
//   i_vec       b[row], signed Q16.16
//   o_valid     result valid, held until i_ready
//   i_ready     downstream accepts the result
//   o_x         solution x0..x2, signed Q16.16
//   o_singular  det(A) was zero; o_x is forced to zero
//
// Also contains the two shared arithmetic units:
//   fip_32_3b3_det  3-stage pipelined 3x3 determinant (wrapping products)
//   fip_32_div      combinational Q-format divide with optional saturation
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// fip_32_3b3_det: 3x3 determinant by cofactor expansion along row 0.
//   i_clk, i_rstn (synchronous, active-low), i_en (one matrix per cycle),
//   i_matrix (Q format, FRA_BITS fraction bits), o_valid / o_det three
//   cycles after i_en. Every product is truncated back to 32 bits, so
//   results wrap rather than saturate.
// ---------------------------------------------------------------------------
module fip_32_3b3_det #(
    parameter int FRA_BITS = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic                        i_en,
    input  logic signed [0:2][0:2][31:0] i_matrix,
    output logic                        o_valid,
    output logic signed [31:0]          o_det
);

    // Full-precision signed product of two 32-bit fixed-point words.
    function automatic logic signed [63:0] wide_mul(input logic [31:0] a,
                                                    input logic [31:0] b);
        logic signed [63:0] wa;
        logic signed [63:0] wb;
        wa = {{32{a[31]}}, a};
        wb = {{32{b[31]}}, b};
        return wa * wb;
    endfunction

    logic                v_s1, v_s2, v_s3;
    logic signed [31:0]  row_s1   [0:2];
    logic signed [31:0]  minor_s1 [0:2];
    logic signed [31:0]  term_s2  [0:2];
    logic signed [31:0]  det_s3;

    logic signed [63:0]  minor_w  [0:2];
    logic signed [63:0]  term_w   [0:2];

    // Minors are differences of full products, rescaled once, so the
    // only rounding per minor is a single arithmetic shift.
    always_comb begin
        minor_w[0] = wide_mul(i_matrix[1][1], i_matrix[2][2]) - wide_mul(i_matrix[1][2], i_matrix[2][1]);
        minor_w[1] = wide_mul(i_matrix[1][0], i_matrix[2][2]) - wide_mul(i_matrix[1][2], i_matrix[2][0]);
        minor_w[2] = wide_mul(i_matrix[1][0], i_matrix[2][1]) - wide_mul(i_matrix[1][1], i_matrix[2][0]);
        for (int i = 0; i < 3; i++) begin
            term_w[i] = wide_mul(row_s1[i], minor_s1[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            v_s1 <= 1'b0;
            v_s2 <= 1'b0;
            v_s3 <= 1'b0;
        end else begin
            v_s1 <= i_en;
            v_s2 <= v_s1;
            v_s3 <= v_s2;
        end
    end

    // Data registers only load when their stage carries a valid matrix.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int i = 0; i < 3; i++) begin
                row_s1[i]   <= i_matrix[0][i];
                minor_s1[i] <= 32'(minor_w[i] >>> FRA_BITS);
            end
        end
        if (v_s1) begin
            for (int i = 0; i < 3; i++) begin
                term_s2[i] <= 32'(term_w[i] >>> FRA_BITS);
            end
        end
        if (v_s2) begin
            det_s3 <= term_s2[0] - term_s2[1] + term_s2[2];
        end
    end

    assign o_valid = v_s3;
    assign o_det   = det_s3;

endmodule

// ---------------------------------------------------------------------------
// fip_32_div: o_q = i_x / i_y in Q format, truncating toward zero.
//   With SAT != 0 an out-of-range quotient clips to 0x7fffffff/0x80000000,
//   otherwise the low 32 bits are returned. A zero divisor yields the
//   saturated value matching the sign of i_x.
// ---------------------------------------------------------------------------
module fip_32_div #(
    parameter int FRA_BITS = 16,
    parameter int SAT      = 1
) (
    input  logic signed [31:0] i_x,
    input  logic signed [31:0] i_y,
    output logic signed [31:0] o_q
);

    localparam logic signed [63:0] Q_MAX = 64'sh0000_0000_7fff_ffff;
    localparam logic signed [63:0] Q_MIN = 64'shffff_ffff_8000_0000;

    logic signed [63:0] num;
    logic signed [63:0] den;
    logic signed [63:0] quo;

    always_comb begin
        num = {{32{i_x[31]}}, i_x};
        num = num <<< FRA_BITS;
        den = {{32{i_y[31]}}, i_y};
        if (i_y == 32'sd0) begin
            quo = i_x[31] ? Q_MIN : Q_MAX;
        end else begin
            quo = num / den;
        end

        o_q = quo[31:0];
        if (SAT != 0) begin
            if (quo > Q_MAX) begin
                o_q = 32'h7fff_ffff;
            end else if (quo < Q_MIN) begin
                o_q = 32'h8000_0000;
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Top-level Cramer sequencer.
// ---------------------------------------------------------------------------
module fip_32_cramer_ctrl #(
    parameter int FRA_BITS = 16,
    parameter int SAT      = 1,
    parameter int DET_LAT  = 3
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic signed [0:2][0:2][31:0] i_matrix,
    input  logic signed [0:2][31:0]      i_vec,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [0:2][31:0]      o_x,
    output logic                         o_singular
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DIV,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [0:2][0:2][31:0] a_reg;
    logic signed [0:2][31:0]      b_reg;
    logic signed [31:0]           d [0:3];

    logic [1:0] issue_cnt;
    logic [2:0] collect_cnt;
    logic [1:0] div_cnt;
    logic [1:0] repl_col;
    logic [1:0] div_sel;

    logic                         det_en;
    logic signed [0:2][0:2][31:0] det_in;
    logic                         det_valid;
    logic signed [31:0]           det_out;
    logic signed [31:0]           div_q;

    logic collect_fire;
    logic collect_done;

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign det_en   = (state == ISSUE);
    assign repl_col = issue_cnt - 2'd1;
    assign div_sel  = div_cnt + 2'd1;

    // A det result beyond the fourth has no slot and is dropped.
    assign collect_fire = det_valid && (collect_cnt != 3'd4);
    // Collection finishes either on the fourth result itself or later.
    assign collect_done = (collect_cnt == 3'd4) || (det_valid && collect_cnt == 3'd3);

    // Issue k=0 is A itself; k=1..3 replace column k-1 with b.
    always_comb begin
        det_in = a_reg;
        if (issue_cnt != 2'd0) begin
            for (int r = 0; r < 3; r++) begin
                det_in[r][repl_col] = b_reg[r];
            end
        end
    end

    fip_32_3b3_det #(
        .FRA_BITS (FRA_BITS)
    ) u_det (
        .i_clk    (i_clk),
        .i_rstn   (~i_rst),
        .i_en     (det_en),
        .i_matrix (det_in),
        .o_valid  (det_valid),
        .o_det    (det_out)
    );

    fip_32_div #(
        .FRA_BITS (FRA_BITS),
        .SAT      (SAT)
    ) u_div (
        .i_x (d[div_sel]),
        .i_y (d[0]),
        .o_q (div_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_valid)               state_nxt = ISSUE;
            ISSUE: if (issue_cnt == 2'd3)     state_nxt = WAIT;
            // d[0] is always stored before the last result arrives.
            WAIT:  if (collect_done)          state_nxt = (d[0] != 32'sd0) ? DIV : DONE;
            DIV:   if (div_cnt == 2'd2)       state_nxt = DONE;
            DONE:  if (i_ready)               state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, determinant collection, quotients.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            issue_cnt   <= 2'd0;
            collect_cnt <= 3'd0;
            div_cnt     <= 2'd0;
            o_x         <= '0;
            o_singular  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                d[i] <= 32'sd0;
            end
        end else begin
            // Collection runs independently of state because results
            // start returning while later issues are still going out.
            if (collect_fire) begin
                d[collect_cnt[1:0]] <= det_out;
                collect_cnt         <= collect_cnt + 3'd1;
            end

            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_reg       <= i_matrix;
                        b_reg       <= i_vec;
                        issue_cnt   <= 2'd0;
                        collect_cnt <= 3'd0;
                        div_cnt     <= 2'd0;
                    end
                end
                ISSUE: begin
                    issue_cnt <= issue_cnt + 2'd1;
                end
                WAIT: begin
                    if (collect_done) begin
                        if (d[0] == 32'sd0) begin
                            o_x        <= '0;
                            o_singular <= 1'b1;
                        end else begin
                            o_singular <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    o_x[div_cnt] <= div_q;
                    div_cnt      <= div_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Simulation checks: the det unit must return each issue exactly
    // DET_LAT cycles later, and never more than four results per solve.
    logic [DET_LAT:1] issue_age;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            issue_age <= '0;
        end else begin
            issue_age <= {issue_age[DET_LAT-1:1], det_en};
            assert (det_valid == issue_age[DET_LAT]);
            assert (!(det_valid && collect_cnt == 3'd4));
        end
    end

endmodule

// File: tb/tb_fip_32_cramer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fip_32_cramer_ctrl
//
// Directed bench for the Cramer sequencer: identity and scaled systems,
// a singular matrix, divider saturation, result back-pressure with a
// back-to-back request, and a reset in the middle of a solve.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fip_32_cramer_ctrl;

    localparam logic [31:0] ONE = 32'h0001_0000;

    logic                         clk;
    logic                         rst;
    logic                         i_valid;
    logic                         o_ready;
    logic signed [0:2][0:2][31:0] i_matrix;
    logic signed [0:2][31:0]      i_vec;
    logic                         o_valid;
    logic                         i_ready;
    logic signed [0:2][31:0]      o_x;
    logic                         o_singular;

    int pass_count  = 0;
    int total_count = 0;
    int latency;

    logic [0:2][0:2][31:0] mat_i1, mat_i2, mat_sing, mat_half;
    logic [0:2][31:0]      vec_123, vec_246, vec_111, vec_big;

    fip_32_cramer_ctrl #(
        .FRA_BITS (16),
        .SAT      (1),
        .DET_LAT  (3)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_matrix   (i_matrix),
        .i_vec      (i_vec),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_x        (o_x),
        .o_singular (o_singular)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    endtask

    // Presents a request at the current falling edge and waits (bounded)
    // for o_valid. Returns the cycle count from accept, or -1 on timeout.
    // With hold_busy, i_valid stays high carrying different data while busy.
    task automatic applyStimulus(input logic [0:2][0:2][31:0] mat,
                                 input logic [0:2][31:0] vec,
                                 input bit hold_busy,
                                 output int lat);
        i_matrix = mat;
        i_vec    = vec;
        i_valid  = 1'b1;
        checkOutput("accept_ready", {31'd0, o_ready}, 32'd1);
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) checkOutput("busy_ready", {31'd0, o_ready}, 32'd0);
            if (o_valid) begin
                lat = cyc;
                break;
            end
            if (hold_busy) begin
                i_matrix = ~mat;
                i_vec    = ~vec;
            end else begin
                i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [31:0] x0,
                               input logic [31:0] x1, input logic [31:0] x2,
                               input logic sing);
        checkOutput({tag, "_x0"}, o_x[0], x0);
        checkOutput({tag, "_x1"}, o_x[1], x1);
        checkOutput({tag, "_x2"}, o_x[2], x2);
        checkOutput({tag, "_sing"}, {31'd0, o_singular}, {31'd0, sing});
    endtask

    // Handshakes the result at the current falling edge and checks the
    // controller is idle one cycle later.
    task automatic releaseResult(input string tag);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        checkOutput({tag, "_rel_valid"}, {31'd0, o_valid}, 32'd0);
        checkOutput({tag, "_rel_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        mat_i1   = {ONE, 32'd0, 32'd0, 32'd0, ONE, 32'd0, 32'd0, 32'd0, ONE};
        mat_i2   = {32'h0002_0000, 32'd0, 32'd0, 32'd0, 32'h0002_0000, 32'd0,
                    32'd0, 32'd0, 32'h0002_0000};
        mat_sing = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
                    32'h0004_0000, 32'h0005_0000, 32'h0006_0000,
                    32'h0007_0000, 32'h0008_0000, 32'h0009_0000};
        mat_half = {32'h0000_8000, 32'd0, 32'd0, 32'd0, 32'h0000_8000, 32'd0,
                    32'd0, 32'd0, 32'h0000_8000};
        vec_123  = {32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
        vec_246  = {32'h0002_0000, 32'h0004_0000, 32'h0006_0000};
        vec_111  = {ONE, ONE, ONE};
        vec_big  = {32'h7530_0000, 32'd0, 32'd0};

        rst      = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_matrix = '0;
        i_vec    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkResult("rst", 32'd0, 32'd0, 32'd0, 1'b0);

        $display("[TB] test 1: identity");
        applyStimulus(mat_i1, vec_123, 1'b0, latency);
        checkOutput("t1_latency", latency, 32'd11);
        checkResult("t1", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);
        releaseResult("t1");

        $display("[TB] test 2: 2*I with i_valid held while busy");
        applyStimulus(mat_i2, vec_246, 1'b1, latency);
        checkOutput("t2_latency", latency, 32'd11);
        checkResult("t2", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);
        releaseResult("t2");

        $display("[TB] test 3: singular");
        applyStimulus(mat_sing, vec_111, 1'b0, latency);
        checkOutput("t3_latency", latency, 32'd8);
        checkResult("t3", 32'd0, 32'd0, 32'd0, 1'b1);
        releaseResult("t3");

        $display("[TB] test 4: saturating divide");
        applyStimulus(mat_half, vec_big, 1'b0, latency);
        checkOutput("t4_latency", latency, 32'd11);
        checkResult("t4", 32'h7fff_ffff, 32'd0, 32'd0, 1'b0);
        releaseResult("t4");

        $display("[TB] test 5: back-pressure then back-to-back request");
        applyStimulus(mat_i1, vec_123, 1'b0, latency);
        checkOutput("t5_latency", latency, 32'd11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t5_hold_valid", {31'd0, o_valid}, 32'd1);
            checkOutput("t5_hold_ready", {31'd0, o_ready}, 32'd0);
            checkResult("t5_hold", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);
        end
        releaseResult("t5");
        applyStimulus(mat_i2, vec_246, 1'b0, latency);
        checkOutput("t5b_latency", latency, 32'd11);
        checkResult("t5b", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);
        releaseResult("t5b");

        $display("[TB] test 6: reset mid-solve");
        i_matrix = mat_i1;
        i_vec    = vec_123;
        i_valid  = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_rst_ready", {31'd0, o_ready}, 32'd1);
        checkOutput("t6_rst_valid", {31'd0, o_valid}, 32'd0);
        checkResult("t6_rst", 32'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(mat_i2, vec_246, 1'b0, latency);
        checkOutput("t6_latency", latency, 32'd11);
        checkResult("t6", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0);
        releaseResult("t6");

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/fip_32_cramer_ctrl.md
Name: fip_32_cramer_ctrl

Overview:
Sequencer that solves a 3x3 linear system A·x = b in Q16.16 by Cramer's rule, for ray/triangle barycentric solves. It owns one pipelined fip_32_3b3_det instance and one combinational fip_32_div instance and time-multiplexes both. The four determinants det(A), det(A0), det(A1), det(A2) are computed on the shared det unit, followed by three divides on the shared divider. Sits between the ray-setup stage (upstream valid/ready) and the hit-test stage (downstream valid/ready).

Parameters:
FRA_BITS, 16, fractional bits, passed to the divider.
SAT, 1, divider saturation enable: 1 clips to 0x7fffffff/0x80000000.
DET_LAT, 3, latency of the det unit in cycles, i_en to o_valid. Used for the latency spec only; the controller counts det o_valid pulses.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  upstream request valid
o_ready  out  1  controller idle and able to accept
i_matrix  in  32x[0:2][0:2] signed  A[row][col], Q16.16
i_vec  in  32x[0:2] signed  b, Q16.16
o_valid  out  1  result valid
i_ready  in  1  downstream accepts result
o_x  out  32x[0:2] signed  solution x0..x2, Q16.16
o_singular  out  1  det(A)==0; o_x forced to 0

Behaviour:
- Single clock i_clk. Reset i_rst is synchronous and active-high. Internal det unit gets i_rstn = ~i_rst.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_singular=0, o_x={0,0,0}. Issue and collect counters are cleared.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready, register A and b, go to ISSUE.
  - Inputs are don't-care outside the accept cycle.
- ISSUE: 4 cycles with det i_en=1, issue counter k=0..3.
  - k=0 issues A.
  - k=1..3 issues A with column (k-1) replaced by b.
  - o_ready=0 from the cycle after accept until return to IDLE.
- WAIT:
  - The det i_en=0 after the 4 issues.
  - Each det o_valid pulse stores o_det into slot d[c], c=0..3, c incremented. Collection may overlap ISSUE.
  - When c reaches 4, go to DIV if d[0]!=0, else go to DONE with o_singular=1 and o_x=0.
- DIV: 3 cycles, j=0..2.
  - Divider inputs are i_x=d[j+1], i_y=d[0].
  - Quotient registered into o_x[j].
  - Then go to DONE with o_singular=0.
- DONE:
  - o_valid=1; o_x and o_singular held stable while i_ready=0.
  - On i_valid... no: on o_valid&&i_ready, o_valid goes to 0 next cycle, state goes to IDLE, o_ready=1 next cycle.
  - There is no same-cycle accept of a new request in DONE.
- Latency with L=DET_LAT, accept at cycle 0:
  - Issues occur in cycles 1-4.
  - Dets are collected in cycles 1+L..4+L.
  - Divides occur in cycles 5+L..7+L.
  - o_valid rises at cycle 8+L (non-singular) or 5+L (singular).
  - Throughput: one solve per 9+L cycles minimum.
- Arithmetic:
  - Det products wrap per the det unit (no saturation).
  - Divide saturates per SAT.
  - Sign is preserved; no rounding beyond the divider's truncation.
- Boundary conditions:
  - A det o_valid arriving when c==4 (cannot occur legally) is ignored. An assertion flags it in simulation.
  - i_valid held high during a busy period: not accepted, no side effect.
  - i_rst mid-operation: next cycle all outputs return to reset values, the det pipeline is flushed, partially collected results are discarded.
  - i_rst during DONE: o_valid drops without a handshake.

Test Plan:
1. A=I (0x00010000 on the diagonal), b=(1.0,2.0,3.0) -> o_valid at cycle 11 (L=3), o_x=(0x00010000,0x00020000,0x00030000), o_singular=0.
2. A=2I (0x00020000 diagonal), b=(2.0,4.0,6.0) -> d[0]=8.0 (0x00080000), o_x=(1.0,2.0,3.0).
3. A=[[1,2,3],[4,5,6],[7,8,9]] (Q16.16), b=(1,1,1) -> o_valid at cycle 8, o_singular=1, o_x=(0,0,0).
4. A=0.5·I (0x00008000), b=(30000.0,0,0), SAT=1 -> d[0]=0.125, d[1]=7500.0, o_x[0]=0x7fffffff, o_x[1]=o_x[2]=0.
5. Test 1 with i_ready=0 for 5 cycles after o_valid -> o_x/o_valid stable; o_ready=0 throughout. After the i_ready pulse: o_valid=0 and o_ready=1 next cycle. A back-to-back request is then accepted and solved correctly.
6. Assert i_rst for 1 cycle during cycle 5 (WAIT) of a solve -> next cycle o_ready=1, o_valid=0, o_x=0. No stale det result corrupts a following request (re-run Test 2 and check the result).
